// File: rtl/dmem_pkg.sv
// ---- dmem_pkg : shared access-size codes and FSM encoding for dmem_lat ----
// ---- rev 1.0 ----
`default_nettype none

package dmem_pkg;

  localparam logic [1:0] DS_BYTE = 2'd0;
  localparam logic [1:0] DS_HALF = 2'd1;
  localparam logic [1:0] DS_WORD = 2'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/dmem_lane.sv
// ---- dmem_lane : fault check, load extract/extend, store byte-lane select ----
// ---- rev 1.0 ----
`default_nettype none

module dmem_lane
  import dmem_pkg::*;
#(
  parameter int          SIZE   = 32768,
  parameter logic [31:0] OFFSET = 32'h0,
  parameter int          AW     = 15
) (
  input  logic [0:31]      addr,
  input  logic [0:31]      wdata,
  input  logic [0:1]       dsize,
  input  logic             sign_ext,
  input  logic [0:3][0:7]  rd_byte,
  output logic             fault,
  output logic [AW-1:0]    index,
  output logic [0:31]      load_data,
  output logic [0:3][0:7]  wr_byte,
  output logic [0:3]       wr_mask
);

  logic [32:0] phys;
  logic [33:0] last;

  // An address below OFFSET wraps to a huge physical value, so the range test catches it too.
  assign phys  = {1'b0, addr} - {1'b0, OFFSET};
  assign last  = {1'b0, phys} + {32'b0, dsize};
  assign index = phys[AW-1:0];

  assign fault = (dsize == 2'd2)
               | ((dsize == DS_HALF) & addr[31])
               | ((dsize == DS_WORD) & (addr[30:31] != 2'b00))
               | (last >= 34'(SIZE));

  always_comb begin
    load_data = rd_byte;
    case (dsize)
      DS_HALF: load_data = {{16{sign_ext & rd_byte[0][0]}}, rd_byte[0], rd_byte[1]};
      DS_BYTE: load_data = {{24{sign_ext & rd_byte[0][0]}}, rd_byte[0]};
      default: load_data = rd_byte;
    endcase
  end

  always_comb begin
    wr_byte = wdata;
    wr_mask = 4'b1111;
    case (dsize)
      DS_HALF: begin
        wr_byte[0] = wdata[16:23];
        wr_byte[1] = wdata[24:31];
        wr_mask    = 4'b1100;
      end
      DS_BYTE: begin
        wr_byte[0] = wdata[24:31];
        wr_mask    = 4'b1000;
      end
      DS_WORD: wr_mask = 4'b1111;
      default: wr_mask = 4'b0000;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/dmem_lat.sv
// ---- dmem_lat : big-endian data memory with request/ready handshake and fixed latency ----
// ---- rev 1.0 ----
`default_nettype none

module dmem_lat
  import dmem_pkg::*;
#(
  parameter int          SIZE    = 32768,
  parameter logic [31:0] OFFSET  = 32'h0,
  parameter int          LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        writeEnable,
  input  logic [0:31] addr,
  input  logic [0:31] wData,
  input  logic [0:1]  dsize,
  input  logic        signExt,
  output logic        ready,
  output logic        done,
  output logic        fault,
  output logic [0:31] rData
);

  localparam int         AW       = (SIZE > 1) ? $clog2(SIZE) : 1;
  localparam logic [3:0] CNT_INIT = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

  logic [0:7] mem [0:SIZE-1];

  state_t     state, state_nx;
  logic [3:0] cnt, cnt_nx;
  logic       accept, enter_done;

  logic        eff_we, eff_se;
  logic [0:31] eff_addr, eff_wdata;
  logic [0:1]  eff_ds;

  logic            lane_fault;
  logic [AW-1:0]   index;
  logic [0:31]     load_data;
  logic [0:3][0:7] rd_byte, wr_byte;
  logic [0:3]      wr_mask;

  assign ready  = (state != WAIT);
  assign accept = req & ready;

  // With LATENCY=1 the accept edge is also the commit edge, so the live request is used.
  generate
    if (LATENCY == 1) begin : g_direct
      assign eff_we    = writeEnable;
      assign eff_se    = signExt;
      assign eff_addr  = addr;
      assign eff_wdata = wData;
      assign eff_ds    = dsize;
    end else begin : g_latched
      logic        we_q, se_q;
      logic [0:31] addr_q, wdata_q;
      logic [0:1]  ds_q;
      always_ff @(posedge clk) begin
        if (accept) begin
          we_q    <= writeEnable;
          se_q    <= signExt;
          addr_q  <= addr;
          wdata_q <= wData;
          ds_q    <= dsize;
        end
      end
      assign eff_we    = we_q;
      assign eff_se    = se_q;
      assign eff_addr  = addr_q;
      assign eff_wdata = wdata_q;
      assign eff_ds    = ds_q;
    end
  endgenerate

  dmem_lane #(.SIZE(SIZE), .OFFSET(OFFSET), .AW(AW)) u_lane (
    .addr     (eff_addr),
    .wdata    (eff_wdata),
    .dsize    (eff_ds),
    .sign_ext (eff_se),
    .rd_byte  (rd_byte),
    .fault    (lane_fault),
    .index    (index),
    .load_data(load_data),
    .wr_byte  (wr_byte),
    .wr_mask  (wr_mask)
  );

  generate
    for (genvar g = 0; g < 4; g++) begin : g_rd
      assign rd_byte[g] = mem[index + AW'(g)];
    end
  endgenerate

  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt;
    enter_done = 1'b0;
    case (state)
      WAIT: begin
        if (cnt == 4'd0) begin
          state_nx   = DONE;
          enter_done = 1'b1;
        end else begin
          cnt_nx = cnt - 4'd1;
        end
      end
      default: begin
        if (accept) begin
          if (LATENCY == 1) begin
            state_nx   = DONE;
            enter_done = 1'b1;
          end else begin
            state_nx = WAIT;
            cnt_nx   = CNT_INIT;
          end
        end else begin
          state_nx = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= 4'd0;
      done  <= 1'b0;
      fault <= 1'b0;
      rData <= 32'h0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      done  <= enter_done;
      fault <= enter_done & lane_fault;
      if (enter_done && !lane_fault && !eff_we) rData <= load_data;
    end
  end

  // Storage has no reset; the reset term only blocks a commit racing an asserted reset.
  always_ff @(posedge clk) begin
    if (enter_done && eff_we && !lane_fault && !reset) begin
      for (int k = 0; k < 4; k++) begin
        if (wr_mask[2'(k)]) mem[index + AW'(k)] <= wr_byte[2'(k)];
      end
    end
  end

endmodule

`default_nettype wire

// File: doc/dmem_lat.md
# dmem_lat

Parametrised, multi-cycle data memory for the pipelined processor, replacing the single-cycle combinational-read data memory. It accepts one load or store at a time over a request/ready handshake and completes it after a configurable latency. Loads return right-justified, zero- or sign-extended data. Misaligned, invalid-size and out-of-range accesses raise a fault and leave memory unchanged. The memory stage stalls on `ready`/`done`, which lets the pipeline exercise realistic memory latency.

## Interface
Parameters:
- SIZE, 32768: capacity in bytes; big-endian byte array `mem[0:SIZE-1]`, each entry `[0:7]`.
- OFFSET, 0: base address; physical address = `addr - OFFSET`.
- LATENCY, 1: cycles from accept edge to completion, legal range 1..15.

Ports:
- clk  in  1  clock, all state on rising edge.
- reset  in  1  asynchronous, active-high; clears control state only, not `mem`.
- req  in  1  access request; sampled only when `ready`=1.
- writeEnable  in  1  1 = store, 0 = load; sampled with `req`.
- addr  in  [0:31]  byte address.
- wData  in  [0:31]  store data, right-justified (byte in `[24:31]`, half in `[16:31]`).
- dsize  in  [0:1]  bytes-1: 3 = word, 1 = half, 0 = byte, 2 = illegal.
- signExt  in  1  load sign-extends when 1, zero-extends when 0.
- ready  out  1  block can accept a request this cycle.
- done  out  1  one-cycle completion pulse.
- rData  out  [0:31]  load result; valid while `done`=1, held until the next completion.
- fault  out  1  with `done`: access was rejected.

## Operation
- States: IDLE, WAIT, DONE.
- Accept: `req`=1 and `ready`=1 at a rising edge. All request inputs (`addr`, `wData`, `dsize`, `writeEnable`, `signExt`) are latched at that edge. Later changes are ignored.
- LATENCY=1: accept goes straight to DONE. LATENCY>1: accept goes to WAIT with counter = LATENCY-2. WAIT decrements each cycle and goes to DONE when the counter is 0.
- DONE: `done`=1, `ready`=1. A request in DONE is accepted, so the next state is DONE or WAIT. Otherwise the next state is IDLE.
- IDLE: `ready`=1, `done`=0. WAIT: `ready`=0, `done`=0.
- Fault checks are evaluated on the latched request:
  - `dsize`=2;
  - half with `addr[31]`=1;
  - word with `addr[30:31]` != 0;
  - phys+bytes-1 >= SIZE, computed in 33 bits so that `addr`<OFFSET also faults.
- On fault: no write; `rData` is unchanged; `fault`=1 during `done`.
- Store commit: bytes are written big-endian at the edge entering DONE. Word writes phys..phys+3 from `[0:31]`, half writes phys, phys+1 from `[16:31]`, byte writes phys from `[24:31]`.
- Load capture: `rData` is registered at the edge entering DONE.
  - Word: `{m[p],m[p+1],m[p+2],m[p+3]}`.
  - Half: `{16x ext, m[p], m[p+1]}`.
  - Byte: `{24x ext, m[p]}`.
  - ext is the MSB of the loaded data when `signExt`=1, else 0.
- Read-after-write: a load captures all stores committed at earlier edges.
- Reset (any time): state to IDLE, counter cleared, `done`=0, `fault`=0, `rData`=0. An in-flight store is dropped; no partial write occurs.

## Timing
- Reset values: `ready`=1, `done`=0, `fault`=0, `rData`=32'h0.
- Accept edge E0. `done` is high in the cycle after edge E0+LATENCY-1.
- Throughput is one access per LATENCY cycles with `req` held high.
- `ready` is a registered function of state only, with no combinational path from `req`.
- `done`, `fault` and `rData` are registered.
- Reset deasserted mid-cycle: the first accept is possible at the next rising edge.

## Structure
- Shared package `dmem_pkg` holds:
  - dsize constants `DS_BYTE`=0, `DS_HALF`=1, `DS_WORD`=3;
  - state encoding IDLE/WAIT/DONE.
- Sub-module `dmem_lane` (combinational) contains the fault check, load extract/extension and store byte-lane selection. The top level holds the FSM, counter, latches and `mem`.
- `mem` is hierarchically visible so testbenches can `$readmemh` into it.

## Test plan
- LATENCY=1, store word 32'hDEADBEEF at 0x100, then load word 0x100 back-to-back: `done` on consecutive cycles; `rData`=32'hDEADBEEF; mem[0x100..0x103]=DE,AD,BE,EF.
- LATENCY=3, load byte 0x103 with signExt=1 after the above: `ready` low 2 cycles; `done` 3 cycles after accept; `rData`=32'hFFFFFFEF. With signExt=0: 32'h000000EF.
- Store half 16'h8001 at 0x102, load half signExt=1: `rData`=32'hFFFF8001; mem[0x100..0x101] still DE,AD.
- Faults: word at 0x102, half at 0x101, dsize=2, addr=SIZE-2 word, OFFSET=0x1000 with addr=0x0FFF byte. Each gives `done`=`fault`=1, memory unchanged, `rData` holds its prior value.
- LATENCY=4, store word at 0x200, assert reset 2 cycles after accept: `ready`=1, `done`=0 after reset; mem[0x200..0x203] unchanged.
- `req` low throughout and `addr`/`wData` toggling: no `done`, no memory change. A request held while `ready`=0 is accepted only at the DONE/IDLE edge.
